// File: rtl/life_pkg.sv
// life_pkg: shared FSM state encoding and grid cell indexing for the Life engine
package life_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALT} life_state_t;

    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction
endpackage

// File: rtl/life_next_gen.sv
// life_next_gen: combinational Game-of-Life rule applied to every cell of the grid
module life_next_gen
    import life_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int TORUS = 0
) (
    input  logic [ROWS*COLS-1:0] cur,
    output logic [ROWS*COLS-1:0] nxt
);
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [8:0] nb;
            logic [3:0] n;
            // k walks the 3x3 window; the wrapped index is always in range and ON masks it off-torus
            for (genvar k = 0; k < 9; k++) begin : g_nb
                localparam int RR  = r + k / 3 - 1;
                localparam int CC  = c + k % 3 - 1;
                localparam bit ON  = RR >= 0 && RR < ROWS && CC >= 0 && CC < COLS;
                localparam int IDX = cell_idx((RR + ROWS) % ROWS, (CC + COLS) % COLS, COLS);
                assign nb[k] = k != 4 && (TORUS != 0 || ON) && cur[IDX];
            end
            always_comb begin
                n = '0;
                for (int i = 0; i < 9; i++) n = n + {3'b0, nb[i]};
            end
            assign nxt[cell_idx(r, c, COLS)] = n == 4'd3 || (cur[cell_idx(r, c, COLS)] && n == 4'd2);
        end
    end
endmodule

// File: rtl/life_engine_ctrl.sv
// life_engine_ctrl: Life grid register, generation FSM, rate divider, counter and status flags
module life_engine_ctrl
    import life_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int TORUS     = 0,
    parameter int GEN_DIV   = 1,
    parameter int GEN_W     = 16,
    parameter int AUTO_HALT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 run,
    input  logic                 step,
    output logic [ROWS*COLS-1:0] grid,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 gen_valid,
    output logic                 running,
    output logic                 stable,
    output logic                 osc2,
    output logic                 extinct
);
    localparam int N = ROWS * COLS;
    localparam int DIV_W = GEN_DIV > 1 ? $clog2(GEN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(GEN_DIV - 1);

    life_state_t      state_q, state_d;
    logic [N-1:0]     grid_q, grid_d, prev_q, prev_d, nxt;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             valid_q, valid_d, adv, halt_hit;

    life_next_gen #(.ROWS(ROWS), .COLS(COLS), .TORUS(TORUS)) u_next (.cur(grid_q), .nxt(nxt));

    // prev_grid only holds a real generation once something has advanced since load
    always_comb begin
        stable   = nxt == grid_q;
        osc2     = gen_q != '0 && nxt == prev_q && !stable;
        extinct  = grid_q == '0;
        halt_hit = AUTO_HALT != 0 && (stable || osc2 || extinct);
    end

    always_comb begin
        state_d = state_q;
        grid_d  = grid_q;
        prev_d  = prev_q;
        gen_d   = gen_q;
        div_d   = div_q;
        adv     = 1'b0;
        if (load) begin
            grid_d  = seed;
            prev_d  = '0;
            gen_d   = '0;
            div_d   = '0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = run ? RUN : IDLE;
                    adv     = !run && step;
                end
                RUN: begin
                    state_d = !run ? IDLE : halt_hit ? HALT : RUN;
                    adv     = run && !halt_hit && div_q == DIV_LAST;
                    div_d   = (!run || halt_hit || adv) ? '0 : div_q + 1'b1;
                end
                HALT: state_d = run ? HALT : IDLE;
                default: state_d = IDLE;
            endcase
            if (adv) begin
                prev_d = grid_q;
                grid_d = nxt;
                gen_d  = &gen_q ? gen_q : gen_q + 1'b1;
            end
        end
        valid_d = adv;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grid_q  <= '0;
            prev_q  <= '0;
            gen_q   <= '0;
            div_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            prev_q  <= prev_d;
            gen_q   <= gen_d;
            div_q   <= div_d;
            valid_q <= valid_d;
        end
    end

    assign grid      = grid_q;
    assign gen_count = gen_q;
    assign gen_valid = valid_q;
    assign running   = state_q == RUN;
endmodule

// File: tb/tb_life_engine_ctrl.sv
// tb_life_engine_ctrl: three controller configurations checked every cycle against a behavioural Life model
module tb_life_engine_ctrl;
    typedef struct {
        int          st;
        logic [63:0] g;
        logic [63:0] p;
        int          gen;
        int          dv;
        bit          v;
    } ms_t;

    localparam logic [63:0] BL = 64'h0000_0000_1C00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0, run = 1'b0, step = 1'b0;
    logic [63:0] seed = '0;
    logic [63:0] a_grid, b_grid, c_grid;
    logic [15:0] a_gen, b_gen;
    logic [1:0]  c_gen;
    logic        a_v, a_r, a_s, a_o, a_e;
    logic        b_v, b_r, b_s, b_o, b_e;
    logic        c_v, c_r, c_s, c_o, c_e;
    ms_t         ma, mb, mc;
    int          ncmp = 0, nfail = 0;
    bit          armed = 1'b0;

    always #5 clk = ~clk;

    life_engine_ctrl #(.ROWS(8), .COLS(8), .TORUS(0), .GEN_DIV(1), .GEN_W(16), .AUTO_HALT(1)) u_a (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
        .grid(a_grid), .gen_count(a_gen), .gen_valid(a_v), .running(a_r),
        .stable(a_s), .osc2(a_o), .extinct(a_e));
    life_engine_ctrl #(.ROWS(8), .COLS(8), .TORUS(1), .GEN_DIV(4), .GEN_W(16), .AUTO_HALT(0)) u_b (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
        .grid(b_grid), .gen_count(b_gen), .gen_valid(b_v), .running(b_r),
        .stable(b_s), .osc2(b_o), .extinct(b_e));
    life_engine_ctrl #(.ROWS(8), .COLS(8), .TORUS(0), .GEN_DIV(1), .GEN_W(2), .AUTO_HALT(0)) u_c (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .run(run), .step(step),
        .grid(c_grid), .gen_count(c_gen), .gen_valid(c_v), .running(c_r),
        .stable(c_s), .osc2(c_o), .extinct(c_e));

    function automatic logic [63:0] life(input logic [63:0] g, input bit tor);
        logic [63:0] n;
        n = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr, cc;
                        rr = tor ? (r + dr + 8) % 8 : r + dr;
                        cc = tor ? (c + dc + 8) % 8 : c + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            cnt += int'(g[rr * 8 + cc]);
                    end
                n[r * 8 + c] = cnt == 3 || (g[r * 8 + c] && cnt == 2);
            end
        return n;
    endfunction

    // st: 0 idle, 1 running, 2 halted
    function automatic ms_t mnext(input ms_t m, input bit tor, input int div, input bit ah, input int gmax);
        ms_t         o;
        logic [63:0] nx;
        bit          hold, adv;
        o    = m;
        nx   = life(m.g, tor);
        hold = ah && (nx == m.g || (m.gen != 0 && nx == m.p) || m.g == 0);
        adv  = 1'b0;
        if (load) begin
            o.g = seed; o.p = 0; o.gen = 0; o.dv = 0; o.st = 0;
        end else if (m.st == 0) begin
            if (run) o.st = 1;
            else adv = step;
        end else if (m.st == 1) begin
            if (!run) begin o.st = 0; o.dv = 0; end
            else if (hold) begin o.st = 2; o.dv = 0; end
            else if (m.dv == div - 1) begin adv = 1'b1; o.dv = 0; end
            else o.dv = m.dv + 1;
        end else if (!run) o.st = 0;
        if (adv) begin
            o.p = m.g;
            o.g = nx;
            o.gen = m.gen < gmax ? m.gen + 1 : gmax;
        end
        o.v = adv;
        return o;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk(input string t, input ms_t m, input bit tor, input logic [63:0] g, input logic [63:0] gc,
                       input logic v, input logic r, input logic s, input logic o, input logic e);
        logic [63:0] nx;
        nx = life(m.g, tor);
        cmp({t, ".grid"}, g, m.g);
        cmp({t, ".gen_count"}, gc, 64'(m.gen));
        cmp({t, ".gen_valid"}, 64'(v), 64'(m.v));
        cmp({t, ".running"}, 64'(r), 64'(m.st == 1));
        cmp({t, ".stable"}, 64'(s), 64'(nx == m.g));
        cmp({t, ".osc2"}, 64'(o), 64'(m.gen != 0 && nx == m.p && nx != m.g));
        cmp({t, ".extinct"}, 64'(e), 64'(m.g == 0));
    endtask

    always @(posedge clk or posedge reset)
        if (reset) begin
            ma <= '{0, 64'h0, 64'h0, 0, 0, 1'b0};
            mb <= '{0, 64'h0, 64'h0, 0, 0, 1'b0};
            mc <= '{0, 64'h0, 64'h0, 0, 0, 1'b0};
        end else begin
            ma <= mnext(ma, 1'b0, 1, 1'b1, 65535);
            mb <= mnext(mb, 1'b1, 4, 1'b0, 65535);
            mc <= mnext(mc, 1'b0, 1, 1'b0, 3);
        end

    always @(negedge clk)
        if (armed) begin
            chk("A", ma, 1'b0, a_grid, 64'(a_gen), a_v, a_r, a_s, a_o, a_e);
            chk("B", mb, 1'b1, b_grid, 64'(b_gen), b_v, b_r, b_s, b_o, b_e);
            chk("C", mc, 1'b0, c_grid, 64'(c_gen), c_v, c_r, c_s, c_o, c_e);
        end

    task automatic tick(input bit ld, input logic [63:0] sd, input bit rn, input bit st);
        load = ld;
        seed = sd;
        run  = rn;
        step = st;
        @(negedge clk);
    endtask

    initial begin
        int pulses, first, last;
        bit rn;
        @(negedge clk);
        @(negedge clk);
        armed = 1'b1;
        cmp("reset.grid", a_grid, 64'h0);
        cmp("reset.gen_count", 64'(a_gen), 64'h0);
        cmp("reset.gen_valid", 64'(a_v), 64'h0);
        cmp("reset.running", 64'(a_r), 64'h0);
        cmp("reset.extinct", 64'(a_e), 64'h1);
        cmp("reset.stable", 64'(a_s), 64'h1);
        cmp("reset.osc2", 64'(a_o), 64'h0);
        reset = 1'b0;

        tick(1'b1, BL, 1'b0, 1'b0);
        cmp("blink.load", a_grid, BL);
        tick(1'b0, BL, 1'b0, 1'b1);
        cmp("blink.step1.grid", a_grid, 64'h0000_0008_0808_0000);
        cmp("blink.step1.gen", 64'(a_gen), 64'd1);
        cmp("blink.step1.valid", 64'(a_v), 64'd1);
        tick(1'b0, BL, 1'b0, 1'b0);
        cmp("blink.valid_drop", 64'(a_v), 64'd0);
        tick(1'b0, BL, 1'b0, 1'b1);
        cmp("blink.step2.grid", a_grid, BL);
        cmp("blink.step2.osc2", 64'(a_o), 64'd1);
        cmp("blink.step2.gen", 64'(a_gen), 64'd2);

        tick(1'b1, 64'h303, 1'b0, 1'b1);
        cmp("prio.grid", a_grid, 64'h303);
        cmp("prio.gen", 64'(a_gen), 64'd0);
        tick(1'b0, 64'h303, 1'b1, 1'b0);
        cmp("still.enter_run", 64'(a_r), 64'd1);
        tick(1'b0, 64'h303, 1'b1, 1'b0);
        cmp("still.running", 64'(a_r), 64'd0);
        cmp("still.grid", a_grid, 64'h303);
        cmp("still.stable", 64'(a_s), 64'd1);
        cmp("still.gen", 64'(a_gen), 64'd0);
        cmp("still.valid", 64'(a_v), 64'd0);
        tick(1'b0, 64'h303, 1'b1, 1'b1);
        cmp("halt.step_ignored", 64'(a_gen), 64'd0);
        tick(1'b0, 64'h303, 1'b0, 1'b0);

        tick(1'b1, 64'h1, 1'b0, 1'b0);
        tick(1'b0, 64'h1, 1'b1, 1'b0);
        tick(1'b0, 64'h1, 1'b1, 1'b0);
        cmp("extinct.grid", a_grid, 64'h0);
        cmp("extinct.flag", 64'(a_e), 64'd1);
        cmp("extinct.gen", 64'(a_gen), 64'd1);
        tick(1'b0, 64'h1, 1'b1, 1'b0);
        cmp("extinct.halt", 64'(a_r), 64'd0);
        tick(1'b0, 64'h1, 1'b0, 1'b0);

        tick(1'b1, 64'h83, 1'b0, 1'b0);
        tick(1'b0, 64'h83, 1'b0, 1'b1);
        cmp("wrap.flat", a_grid, 64'h0);
        cmp("wrap.flat_extinct", 64'(a_e), 64'd1);
        cmp("wrap.torus", b_grid, 64'h0100_0000_0000_0101);

        tick(1'b1, BL, 1'b0, 1'b0);
        pulses = 0;
        first = -1;
        last = -1;
        for (int i = 0; i < 17; i++) begin
            tick(1'b0, BL, 1'b1, 1'b0);
            if (b_v) begin
                pulses++;
                if (first < 0) first = i;
                last = i;
            end
        end
        cmp("rate.pulses", 64'(pulses), 64'd4);
        cmp("rate.span", 64'(last - first), 64'd12);
        cmp("rate.gen", 64'(b_gen), 64'd4);
        tick(1'b0, BL, 1'b0, 1'b0);
        repeat (4) tick(1'b0, BL, 1'b0, 1'b0);
        cmp("rate.idle", 64'(b_r), 64'd0);
        cmp("rate.frozen", b_grid, BL);

        tick(1'b1, BL, 1'b0, 1'b0);
        repeat (5) tick(1'b0, BL, 1'b0, 1'b1);
        cmp("sat.gen_w2", 64'(c_gen), 64'd3);
        cmp("sat.gen_w16", 64'(a_gen), 64'd5);
        tick(1'b0, BL, 1'b0, 1'b0);

        tick(1'b1, BL, 1'b0, 1'b0);
        tick(1'b0, BL, 1'b1, 1'b0);
        tick(1'b0, BL, 1'b1, 1'b0);
        cmp("rst.pre_running", 64'(a_r), 64'd1);
        cmp("rst.pre_gen", 64'(a_gen), 64'd1);
        #2 reset = 1'b1;
        #1;
        cmp("rst.grid", a_grid, 64'h0);
        cmp("rst.gen", 64'(a_gen), 64'd0);
        cmp("rst.running", 64'(a_r), 64'd0);
        cmp("rst.grid_b", b_grid, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        tick(1'b0, 64'h0, 1'b0, 1'b0);

        rn = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic [63:0] s;
            s = {$urandom, $urandom};
            if ($urandom_range(1) == 1) s &= {$urandom, $urandom};
            if ($urandom_range(7) == 0) rn = !rn;
            tick($urandom_range(15) == 0 || i == 0, s, rn, $urandom_range(3) == 0);
            if ($urandom_range(149) == 0) begin
                #2 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
